// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial bit deserializer.
//   deser_state_e : collection FSM states (COLLECT accepts bits, STALL holds a
//                   finished word in the shift register until the output drains)
//   cnt_width()   : width of the in-word bit counter for a given word width
package serial_deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } deser_state_e;

    // Bits needed to count 0 .. dw-1; never narrower than one bit.
    function automatic int cnt_width(input int dw);
        int w;
        w = $clog2(dw);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Parameterized shift register with selectable bit order.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear; when combined with shift_en the incoming
//                bit lands in an otherwise empty register
//   shift_en   : shift bit_in into the register this cycle
//   bit_in     : serial input bit
//   q          : current register contents
//   q_next     : value the register takes at the next rising edge
module deser_shift_reg #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] q,
    output logic [W-1:0] q_next
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;
    logic [W-1:0] base_s;

    // Next-state: optional clear, then optional shift in the chosen direction.
    always_comb begin
        sr_d   = sr_q;
        base_s = clr ? {W{1'b0}} : sr_q;
        if (shift_en) begin
            if (MSB_FIRST) begin
                sr_d = {base_s[W-2:0], bit_in};
            end else begin
                sr_d = {bit_in, base_s[W-1:1]};
            end
        end else begin
            sr_d = base_s;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {W{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q      = sr_q;
    assign q_next = sr_d;

endmodule

// File: rtl/serial_bit_deserializer.sv
// Serial-to-parallel word assembler with a one-word output holding register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ser_valid/ser_bit     : serial bit stream, accepted when ser_ready is high
//   ser_sof               : start-of-word marker on an accepted bit
//   ser_ready             : bit can be accepted (depends on FSM state only)
//   data_out/out_valid    : assembled word and its valid flag
//   out_ready             : consumer takes data_out this cycle
//   sync_err              : one-cycle pulse when a partial word is discarded
module serial_bit_deserializer
    import serial_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_valid,
    input  logic                  ser_bit,
    input  logic                  ser_sof,
    output logic                  ser_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sync_err
);

    localparam int              CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    deser_state_e            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sync_err_q, sync_err_d;

    logic                    accept_s;
    logic                    restart_s;
    logic                    complete_s;
    logic                    drain_s;
    logic [DATA_WIDTH-1:0]   sr_q_s;
    logic [DATA_WIDTH-1:0]   sr_next_s;

    assign ser_ready  = (state_q == COLLECT);
    assign accept_s   = ser_valid && ser_ready;
    // A start-of-word marker mid-word realigns: the partial word is dropped.
    assign restart_s  = accept_s && ser_sof && (cnt_q != {CNT_W{1'b0}});
    assign complete_s = accept_s && (cnt_q == CNT_LAST) && !restart_s;
    assign drain_s    = out_valid_q && out_ready;

    deser_shift_reg #(
        .W         (DATA_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (restart_s),
        .shift_en (accept_s),
        .bit_in   (ser_bit),
        .q        (sr_q_s),
        .q_next   (sr_next_s)
    );

    // Bit counter and resynchronisation pulse.
    always_comb begin
        cnt_d      = cnt_q;
        sync_err_d = restart_s;
        if (restart_s) begin
            cnt_d = CNT_W'(1);
        end else if (complete_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM next-state and output holding register update.
    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            COLLECT: begin
                if (complete_s) begin
                    // Slot is free if empty or being drained this same cycle.
                    if (!out_valid_q || out_ready) begin
                        data_out_d  = sr_next_s;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end else if (drain_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            STALL: begin
                // Held word sits complete in the shift register.
                if (drain_s) begin
                    data_out_d  = sr_q_s;
                    out_valid_d = 1'b1;
                    state_d     = COLLECT;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= {CNT_W{1'b0}};
            data_out_q  <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;

endmodule
